// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// programmable almost thresholds, occupancy count and sticky error flags.
module sync_fifo_flex #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 1024,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = DEPTH - 4,
   parameter int AE_LEVEL   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF_TH = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_TH = AE_LEVEL[AW:0];
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic [AW:0]           mem_cnt, mem_cnt_n, count_n;
   logic                  stage_vld, stage_vld_n;
   logic                  wr_acc, rd_acc, mem_rd, empty_n;

   always_comb begin
      wr_acc = wr_en && !full;
      rd_acc = rd_en && !empty;
      // In FWFT mode the memory feeds the output stage whenever the stage is
      // free or being popped; in standard mode the memory is read on demand.
      if (FWFT != 0)
         mem_rd = (mem_cnt != '0) && (!stage_vld || rd_acc);
      else
         mem_rd = rd_acc;

      mem_cnt_n = mem_cnt;
      if (wr_acc && !mem_rd)
         mem_cnt_n = mem_cnt + 1'b1;
      else if (!wr_acc && mem_rd)
         mem_cnt_n = mem_cnt - 1'b1;

      count_n = count;
      if (wr_acc && !rd_acc)
         count_n = count + 1'b1;
      else if (!wr_acc && rd_acc)
         count_n = count - 1'b1;

      if (FWFT != 0) begin
         stage_vld_n = mem_rd || (stage_vld && !rd_acc);
         empty_n     = !stage_vld_n;
      end else begin
         stage_vld_n = 1'b0;
         empty_n     = (count_n == '0);
      end
   end

   // Storage array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         mem_cnt      <= '0;
         count        <= '0;
         stage_vld    <= 1'b0;
         dout         <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc)
            wptr <= wptr + 1'b1;
         if (mem_rd) begin
            rptr <= rptr + 1'b1;
            dout <= mem[rptr];
         end
         mem_cnt      <= mem_cnt_n;
         count        <= count_n;
         stage_vld    <= stage_vld_n;
         empty        <= empty_n;
         almost_empty <= (count_n <= AE_TH);
         full         <= (count_n == FULL_CNT);
         almost_full  <= (count_n >= AF_TH);
         if (wr_en && full)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: standard-mode FIFO (DEPTH 16, AF 12, AE 2) plus an FWFT instance.
module tb_sync_fifo_flex;
   localparam int DW = 64;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          wr_en_a = 0, rd_en_a = 0;
   logic [DW-1:0] din_a = '0, dout_a;
   logic          full_a, af_a, empty_a, ae_a, ov_a, un_a;
   logic [4:0]    count_a;

   logic          wr_en_b = 0, rd_en_b = 0;
   logic [DW-1:0] din_b = '0, dout_b;
   logic          full_b, af_b, empty_b, ae_b, ov_b, un_b;
   logic [4:0]    count_b;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] w [0:4];
   logic [DW-1:0] d [0:16];
   logic [DW-1:0] s [0:39];

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en_a), .din(din_a), .full(full_a),
      .almost_full(af_a), .rd_en(rd_en_a), .dout(dout_a), .empty(empty_a),
      .almost_empty(ae_a), .count(count_a), .overflow(ov_a), .underflow(un_a));

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en_b), .din(din_b), .full(full_b),
      .almost_full(af_b), .rd_en(rd_en_b), .dout(dout_b), .empty(empty_b),
      .almost_empty(ae_b), .count(count_b), .overflow(ov_b), .underflow(un_b));

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, " count"}, 64'(count_a), 64'd0);
      check({tag, " empty"}, 64'(empty_a), 64'd1);
      check({tag, " ae"},    64'(ae_a),    64'd1);
      check({tag, " full"},  64'(full_a),  64'd0);
      check({tag, " af"},    64'(af_a),    64'd0);
      check({tag, " dout"},  dout_a,       64'd0);
      check({tag, " ov"},    64'(ov_a),    64'd0);
      check({tag, " un"},    64'(un_a),    64'd0);
   endtask

   initial begin
      for (int i = 0; i < 5; i++)  w[i] = {$urandom, $urandom};
      for (int i = 0; i < 17; i++) d[i] = {$urandom, $urandom};
      for (int i = 0; i < 40; i++) s[i] = {$urandom, $urandom};

      // Reset state
      #12;
      check_reset_a("reset");
      check("reset b empty", 64'(empty_b), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Basic order
      for (int i = 0; i < 5; i++) begin
         wr_en_a = 1; din_a = w[i];
         step();
         check($sformatf("basic wr count %0d", i), 64'(count_a), 64'(i + 1));
         check("basic empty after wr", 64'(empty_a), 64'd0);
      end
      wr_en_a = 0; rd_en_a = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("basic rd data %0d", i), dout_a, w[i]);
         check($sformatf("basic rd count %0d", i), 64'(count_a), 64'(4 - i));
      end
      rd_en_a = 0;
      check("basic end empty", 64'(empty_a), 64'd1);
      check("basic end ov", 64'(ov_a), 64'd0);
      check("basic end un", 64'(un_a), 64'd0);

      // Fill with thresholds, then overflow on the 17th write
      wr_en_a = 1;
      for (int i = 0; i < 16; i++) begin
         din_a = d[i];
         step();
         check($sformatf("fill count %0d", i), 64'(count_a), 64'(i + 1));
         check($sformatf("fill af %0d", i), 64'(af_a), 64'((i + 1) >= 12));
         check($sformatf("fill ae %0d", i), 64'(ae_a), 64'((i + 1) <= 2));
         check($sformatf("fill full %0d", i), 64'(full_a), 64'((i + 1) == 16));
      end
      check("fill ov before 17th", 64'(ov_a), 64'd0);
      din_a = d[16];
      step();
      check("ovf flag", 64'(ov_a), 64'd1);
      check("ovf count", 64'(count_a), 64'd16);
      check("ovf full", 64'(full_a), 64'd1);

      // Simultaneous ops at full: read proceeds, write rejected
      din_a = 64'hDEAD_BEEF_0000_0001; rd_en_a = 1;
      step();
      check("simfull dout", dout_a, d[0]);
      check("simfull count", 64'(count_a), 64'd15);
      check("simfull full", 64'(full_a), 64'd0);
      check("simfull ov", 64'(ov_a), 64'd1);
      wr_en_a = 0;
      for (int i = 1; i < 16; i++) begin
         step();
         check($sformatf("drain data %0d", i), dout_a, d[i]);
         check($sformatf("drain ae %0d", i), 64'(ae_a), 64'((15 - i) <= 2));
         check($sformatf("drain af %0d", i), 64'(af_a), 64'((15 - i) >= 12));
      end
      rd_en_a = 0;
      check("drain empty", 64'(empty_a), 64'd1);
      check("drain un", 64'(un_a), 64'd0);

      // Simultaneous ops at empty: write proceeds, read rejected
      wr_en_a = 1; rd_en_a = 1; din_a = 64'h0BAD_F00D_CAFE_0042;
      step();
      check("simempty un", 64'(un_a), 64'd1);
      check("simempty count", 64'(count_a), 64'd1);
      check("simempty empty", 64'(empty_a), 64'd0);
      check("simempty dout held", dout_a, d[15]);
      wr_en_a = 0;
      step();
      rd_en_a = 0;
      check("simempty rd data", dout_a, 64'h0BAD_F00D_CAFE_0042);
      check("simempty rd count", 64'(count_a), 64'd0);

      // FWFT: first word falls through one edge after the write
      wr_en_b = 1; din_b = 64'hA5;
      step();
      check("fwft N empty", 64'(empty_b), 64'd1);
      check("fwft N count", 64'(count_b), 64'd1);
      wr_en_b = 0;
      step();
      check("fwft N+1 empty", 64'(empty_b), 64'd0);
      check("fwft N+1 dout", dout_b, 64'hA5);
      rd_en_b = 1;
      step();
      rd_en_b = 0;
      check("fwft pop empty", 64'(empty_b), 64'd1);
      check("fwft pop count", 64'(count_b), 64'd0);
      check("fwft pop stale", dout_b, 64'hA5);

      // FWFT streaming, 40 words through a 16-deep buffer (pointers wrap)
      wr_en_b = 1; din_b = s[0];
      step();
      check("stream e0 empty", 64'(empty_b), 64'd1);
      din_b = s[1];
      step();
      check("stream e1 empty", 64'(empty_b), 64'd0);
      check("stream e1 dout", dout_b, s[0]);
      rd_en_b = 1;
      for (int i = 2; i < 40; i++) begin
         din_b = s[i];
         step();
         check($sformatf("stream dout %0d", i - 1), dout_b, s[i - 1]);
         check($sformatf("stream count %0d", i - 1), 64'(count_b), 64'd2);
      end
      wr_en_b = 0;
      step();
      check("stream last dout", dout_b, s[39]);
      check("stream last count", 64'(count_b), 64'd1);
      step();
      rd_en_b = 0;
      check("stream end empty", 64'(empty_b), 64'd1);
      check("stream end count", 64'(count_b), 64'd0);
      check("stream end stale", dout_b, s[39]);
      check("stream un", 64'(un_b), 64'd0);
      check("stream ov", 64'(ov_b), 64'd0);

      // Async reset between edges with 9 words held
      wr_en_a = 1;
      for (int i = 0; i < 9; i++) begin
         din_a = d[i];
         step();
      end
      wr_en_a = 0;
      check("pre-rst count", 64'(count_a), 64'd9);
      #2;
      rst = 1'b1;
      #1;
      check_reset_a("async rst");
      @(negedge clk);
      rst = 1'b0;
      wr_en_a = 1; din_a = 64'h1234;
      step();
      wr_en_a = 0; rd_en_a = 1;
      step();
      rd_en_a = 0;
      check("post-rst dout", dout_a, 64'h1234);
      check("post-rst count", 64'(count_a), 64'd0);
      check("post-rst empty", 64'(empty_a), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
